// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a scaled/flipped sprite, fetches texels from a synchronous ROM
// and writes visible, non-transparent pixels to the framebuffer with write-ready stall.
module sprite_blitter #(
  parameter int CORDW      = 10,
  parameter int SPR_WIDTH  = 32,
  parameter int SPR_HEIGHT = 32,
  parameter int SPR_DATAW  = 4,
  parameter int SCALEW     = 3,
  parameter int FB_WIDTH   = 800,
  parameter int FB_HEIGHT  = 600,
  parameter int FB_SHIFT   = 0,
  parameter int ADDRW      = 19,
  parameter int ROM_LAT    = 1,
  parameter logic [SPR_DATAW-1:0] TRANSP = '1,
  localparam int SAW = $clog2(SPR_WIDTH*SPR_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CORDW-1:0]     sx,
  input  logic [CORDW-1:0]     sy,
  input  logic [SCALEW-1:0]    scale_x,
  input  logic [SCALEW-1:0]    scale_y,
  input  logic                 flip_x,
  input  logic                 flip_y,
  output logic                 busy,
  output logic                 done,
  output logic [SAW-1:0]       spr_addr,
  output logic                 spr_en,
  input  logic [SPR_DATAW-1:0] spr_data,
  output logic [ADDRW-1:0]     fb_addr,
  output logic [SPR_DATAW-1:0] fb_pix,
  output logic                 fb_we,
  input  logic                 fb_ready
);

  localparam int TXW = $clog2(SPR_WIDTH);
  localparam int TYW = $clog2(SPR_HEIGHT);
  localparam int WXW = TXW + SCALEW;
  localparam int WYW = TYW + SCALEW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [CORDW-1:0]  sx_r, sy_r;
  logic [SCALEW-1:0] scx_r, scy_r;
  logic              fx_r, fy_r;
  logic [SCALEW-1:0] cx, cy;
  logic [TXW-1:0]    tx, fx;
  logic [TYW-1:0]    ty, fy;
  logic [WXW-1:0]    wx;
  logic [WYW-1:0]    wy;

  logic [ROM_LAT-1:0] pv, pon;
  logic [ADDRW-1:0]   paddr [ROM_LAT];

  logic             stall, row_end, last_pix, onscreen, pipe_up;
  logic [CORDW:0]   px, py;
  logic [ADDRW-1:0] lin_addr, pix_addr;

  always_comb begin
    busy     = (state == DRAW) || (state == DRAIN);
    fb_we    = pv[ROM_LAT-1] && pon[ROM_LAT-1] && (spr_data != TRANSP);
    fb_addr  = paddr[ROM_LAT-1];
    fb_pix   = pv[ROM_LAT-1] ? spr_data : '0;
    stall    = fb_we && !fb_ready;
    spr_en   = busy && !stall;

    row_end  = (tx == TXW'(SPR_WIDTH-1)) && (cx == scx_r);
    last_pix = row_end && (ty == TYW'(SPR_HEIGHT-1)) && (cy == scy_r);

    fx       = fx_r ? TXW'(SPR_WIDTH-1) - tx : tx;
    fy       = fy_r ? TYW'(SPR_HEIGHT-1) - ty : ty;
    spr_addr = SAW'(fx) + SAW'(fy) * SAW'(SPR_WIDTH);

    // one bit wider than a coordinate so an off-edge pixel cannot wrap back on screen
    px       = (CORDW+1)'(sx_r) + (CORDW+1)'(wx);
    py       = (CORDW+1)'(sy_r) + (CORDW+1)'(wy);
    onscreen = (px < (CORDW+1)'(FB_WIDTH)) && (py < (CORDW+1)'(FB_HEIGHT));

    lin_addr = (ADDRW'(sy_r) + ADDRW'(wy)) * ADDRW'(FB_WIDTH) + ADDRW'(sx_r) + ADDRW'(wx);
    pix_addr = lin_addr >> FB_SHIFT;

    // any valid entry upstream of the output stage keeps DRAIN alive
    pipe_up = 1'b0;
    for (int unsigned i = 0; i + 1 < ROM_LAT; i++) pipe_up = pipe_up | pv[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      sx_r  <= '0;
      sy_r  <= '0;
      scx_r <= '0;
      scy_r <= '0;
      fx_r  <= 1'b0;
      fy_r  <= 1'b0;
      cx    <= '0;
      cy    <= '0;
      tx    <= '0;
      ty    <= '0;
      wx    <= '0;
      wy    <= '0;
      pv    <= '0;
      pon   <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) paddr[i] <= '0;
    end else begin
      done <= 1'b0;

      if (busy && !stall) begin
        pv[0]    <= (state == DRAW);
        pon[0]   <= onscreen;
        paddr[0] <= pix_addr;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
          pv[i]    <= pv[i-1];
          pon[i]   <= pon[i-1];
          paddr[i] <= paddr[i-1];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            sx_r  <= sx;
            sy_r  <= sy;
            scx_r <= scale_x;
            scy_r <= scale_y;
            fx_r  <= flip_x;
            fy_r  <= flip_y;
            cx    <= '0;
            cy    <= '0;
            tx    <= '0;
            ty    <= '0;
            wx    <= '0;
            wy    <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (!stall) begin
            if (row_end) begin
              cx <= '0;
              tx <= '0;
              wx <= '0;
              wy <= wy + 1'b1;
              if (cy == scy_r) begin
                cy <= '0;
                ty <= ty + 1'b1;
              end else begin
                cy <= cy + 1'b1;
              end
            end else begin
              wx <= wx + 1'b1;
              if (cx == scx_r) begin
                cx <= '0;
                tx <= tx + 1'b1;
              end else begin
                cx <= cx + 1'b1;
              end
            end
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stall && !pipe_up) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes expected framebuffer writes,
// a negedge monitor pops and compares them and checks stall hold behaviour.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  sx, sy;
  logic [2:0]  scale_x, scale_y;
  logic        flip_x, flip_y;
  logic        busy, done;
  logic [9:0]  spr_addr;
  logic        spr_en;
  logic [3:0]  spr_data;
  logic [18:0] fb_addr;
  logic [3:0]  fb_pix;
  logic        fb_we, fb_ready;

  always #5 clk = ~clk;

  sprite_blitter #(.CORDW(10), .SPR_WIDTH(32), .SPR_HEIGHT(32), .SPR_DATAW(4),
                   .SCALEW(3), .FB_WIDTH(800), .FB_HEIGHT(600), .FB_SHIFT(0),
                   .ADDRW(19), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sx(sx), .sy(sy),
    .scale_x(scale_x), .scale_y(scale_y), .flip_x(flip_x), .flip_y(flip_y),
    .busy(busy), .done(done), .spr_addr(spr_addr), .spr_en(spr_en),
    .spr_data(spr_data), .fb_addr(fb_addr), .fb_pix(fb_pix), .fb_we(fb_we),
    .fb_ready(fb_ready)
  );

  logic [3:0] rom [1024];
  always @(posedge clk) if (spr_en) spr_data <= rom[spr_addr];

  typedef struct packed {
    logic [18:0] addr;
    logic [3:0]  pix;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  stall_cnt = 0;
  bit  rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: compare each accepted write, and check that stalled outputs hold
  initial begin
    bit          held;
    logic [18:0] h_addr;
    logic [3:0]  h_pix;
    wr_t         e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (held) begin
        check("stall_hold_we", 32'(fb_we), 32'd1);
        check("stall_hold_addr", 32'(fb_addr), 32'(h_addr));
        check("stall_hold_pix", 32'(fb_pix), 32'(h_pix));
      end
      held = 1'b0;
      if (!rst && fb_we) begin
        if (!fb_ready) begin
          stall_cnt++;
          held   = 1'b1;
          h_addr = fb_addr;
          h_pix  = fb_pix;
          check("stall_spr_en", 32'(spr_en), 32'd0);
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_write: got addr %0d pix %0d, required no write", fb_addr, fb_pix);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e.addr));
          check("wr_pix", 32'(fb_pix), 32'(e.pix));
        end
      end
    end
  end

  task automatic push_expected(input int sxv, input int syv, input int scx, input int scy,
                               input bit fxv, input bit fyv);
    int tx, ty, idx, x, y;
    logic [3:0] p;
    wr_t e;
    for (int wy = 0; wy < 32*(scy+1); wy++) begin
      for (int wx = 0; wx < 32*(scx+1); wx++) begin
        tx  = wx / (scx+1);
        ty  = wy / (scy+1);
        idx = (fyv ? 31-ty : ty)*32 + (fxv ? 31-tx : tx);
        p   = rom[idx];
        x   = sxv + wx;
        y   = syv + wy;
        if (p != 4'hF && x < 800 && y < 600) begin
          e.addr = 19'(y*800 + x);
          e.pix  = p;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic do_blit(input int sxv, input int syv, input int scx, input int scy,
                         input bit fxv, input bit fyv, input int ign);
    int n, cnt, lim;
    push_expected(sxv, syv, scx, scy, fxv, fyv);
    stall_cnt = 0;
    n   = 1024*(scx+1)*(scy+1);
    lim = 2*n + 200;
    @(negedge clk);
    sx = 10'(sxv); sy = 10'(syv);
    scale_x = 3'(scx); scale_y = 3'(scy);
    flip_x = fxv; flip_y = fyv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("first_spr_addr", 32'(spr_addr), 32'((fyv ? 31 : 0)*32 + (fxv ? 31 : 0)));
    cnt = 0;
    while (!done && cnt < lim) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ign > 0 && cnt == ign) begin
        start  = 1'b1;
        sx     = 10'd500;
        flip_x = ~fxv;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_cycle", 32'(cnt), 32'(n + 1 + stall_cnt));
    check("done_busy_low", 32'(busy), 32'd0);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; sx = '0; sy = '0;
    scale_x = '0; scale_y = '0; flip_x = 1'b0; flip_y = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 15);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_spr_en", 32'(spr_en), 32'd0);
    check("rst_spr_addr", 32'(spr_addr), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_pix", 32'(fb_pix), 32'd0);
    rst = 1'b0;
    @(posedge clk);

    // unscaled, origin
    do_blit(0, 0, 0, 0, 1'b0, 1'b0, 0);

    // 2x3 scaling with some transparent texels
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 16);
    do_blit(100, 50, 1, 2, 1'b0, 1'b0, 0);

    // both flips: single marker texel at (0,0) lands at (31,31)
    for (int i = 0; i < 1024; i++) rom[i] = 4'hF;
    rom[0] = 4'h5;
    do_blit(200, 100, 0, 0, 1'b1, 1'b1, 0);

    // bottom-right clipping
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 15);
    do_blit(790, 590, 0, 0, 1'b0, 1'b0, 0);

    // random write-ready stalls
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 16);
    rand_ready = 1'b1;
    do_blit(3, 7, 0, 0, 1'b0, 1'b0, 0);
    rand_ready = 1'b0;
    @(posedge clk);

    // reset mid-blit: aborted blit must never report done
    push_expected(0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    sx = '0; sy = '0; scale_x = '0; scale_y = '0; flip_x = 1'b0; flip_y = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy_low", 32'(busy), 32'd0);
    seen = 0;
    repeat (1100) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // fresh blit after abort, with a start pulse while busy that must be ignored
    do_blit(40, 20, 0, 0, 1'b0, 1'b0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Second-generation sprite renderer: copies one SPR_WIDTH×SPR_HEIGHT sprite from a synchronous sprite ROM into the framebuffer. It supports independent X/Y integer scaling, horizontal and vertical flip, and screen-edge clipping. A start/busy/done handshake and a framebuffer write-ready stall make it suitable for a sprite scheduler driving several blits per frame. It sits between the sprite scheduler (control), the sprite ROM (read port) and the framebuffer BRAM (write port).

## Interface
- CORDW, 10, screen coordinate width
- SPR_WIDTH, 32, sprite width in texels
- SPR_HEIGHT, 32, sprite height in texels
- SPR_DATAW, 4, colour-index width
- SCALEW, 3, scale field width; scale s renders (s+1)× per texel
- FB_WIDTH, 800, framebuffer width in pixels
- FB_HEIGHT, 600, framebuffer height in pixels
- FB_SHIFT, 0, right-shift applied to the linear framebuffer address (1 = two pixels per word)
- ADDRW, 19, framebuffer address width
- ROM_LAT, 1, sprite ROM read latency in cycles (≥1)
- TRANSP, all ones, transparent colour index
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin blit; honoured only in IDLE
- sx, sy  in  CORDW  top-left screen position; latched on accepted start
- scale_x, scale_y  in  SCALEW  per-axis scale; latched on accepted start
- flip_x, flip_y  in  1  mirror flags; latched on accepted start
- busy  out  1  high in DRAW and DRAIN
- done  out  1  one-cycle pulse when the blit completes
- spr_addr  out  $clog2(SPR_WIDTH*SPR_HEIGHT)  texel address, row-major
- spr_en  out  1  ROM read/advance enable
- spr_data  in  SPR_DATAW  ROM data, ROM_LAT cycles after the address when spr_en is held
- fb_addr  out  ADDRW  framebuffer write address
- fb_pix  out  SPR_DATAW  pixel colour index
- fb_we  out  1  framebuffer write strobe
- fb_ready  in  1  framebuffer accepts the write this cycle

## Operation
- States: IDLE → DRAW → DRAIN → IDLE.
  - IDLE + start: latch all inputs and go to DRAW.
  - DRAW: after the last pixel is issued, go to DRAIN.
  - DRAIN: once the pipeline is empty, pulse done and go to IDLE.
- start outside IDLE is ignored.
- Output pixel walk: wx in 0..SPR_WIDTH*(scale_x+1)-1, raster order, with wy as the outer loop over 0..SPR_HEIGHT*(scale_y+1)-1.
- Texel coordinates: tx advances once every scale_x+1 pixels and ty once every scale_y+1 rows, both via counters (no divider).
  - tx and cx reset to 0 at each row start.
- Texel fetch: spr_addr = (flip_x ? SPR_WIDTH-1-tx : tx) + (flip_y ? SPR_HEIGHT-1-ty : ty)*SPR_WIDTH.
- Each issued pixel enters a ROM_LAT-deep side pipeline carrying {valid, onscreen, fb_addr}, aligned with spr_data.
  - fb_addr = ((sy+wy)*FB_WIDTH + (sx+wx)) >> FB_SHIFT, computed at ADDRW bits.
  - onscreen = (sx+wx < FB_WIDTH) && (sy+wy < FB_HEIGHT), computed at CORDW+1 bits so it cannot wrap.
- Output stage: fb_we = valid && onscreen && spr_data != TRANSP; fb_pix = spr_data.
- Clipped and transparent pixels still take one cycle each. The walk length is independent of position and content.
- Stall: if fb_we && !fb_ready, the following hold their values:
  - the walk counters and the side pipeline;
  - spr_en = 0;
  - fb_we, fb_addr and fb_pix.
- Otherwise spr_en = 1 in DRAW and DRAIN.
- rst (any state): go to IDLE and clear pipeline valids; no done pulse; a pending write is dropped.

## Timing
- Reset values: busy=0, done=0, fb_we=0, spr_en=0, spr_addr=0, fb_addr=0, fb_pix=0.
- Let N = SPR_WIDTH*(scale_x+1)*SPR_HEIGHT*(scale_y+1), with start accepted at edge t0 and no stalls:
  - busy rises at t0+1;
  - pixel k address is presented at cycle t0+1+k;
  - its write is visible at t0+1+k+ROM_LAT;
  - done is high for one cycle at t0+1+N+ROM_LAT, with busy=0 in that cycle.
- Each stalled cycle delays all later events by exactly one cycle.
- A new start is accepted in the done cycle (state is IDLE).
- fb_we never asserts while busy=0, except in the cycle of the final write when ROM_LAT completes it.
  - Precisely: the final write occurs at t0+N+ROM_LAT with busy=1.

## Test plan
- 32×32 sprite, scale 0/0, sx=sy=0, no flips, fb_ready=1, ROM texel i = i%15 → 32×32 minus transparent writes; fb_addr of texel (x,y) = y*800+x; done at t0+1026.
- scale_x=1, scale_y=2 → each texel written in a 2×3 block; N=6144; done at t0+6146.
- flip_x=1, flip_y=1, marker texel at (0,0) → written at fb (31,31) relative to sx/sy.
- sx=790, sy=590 → no fb_we with x≥800 or y≥600; done timing unchanged.
- fb_ready toggled randomly at 50% → write sequence identical to the no-stall run; done delayed by the number of stall cycles; held fb_addr/fb_pix stable during each stall.
- rst asserted mid-DRAW, then start → no done from the aborted blit; the second blit is complete and correct; start pulsed while busy is ignored.
